// File: rtl/plot_accel_driver.sv
// Host-side initiator for the stack-machine accelerator: streams the RPN queue, sweeps x
// reading back y per column, then terminates; each (x, y/skip) pair leaves on a valid/ready stream.
module plot_accel_driver #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int OUTPUT_QUEUE_SIZE     = 64,
  parameter int HOR_ACTIVE_PIXELS     = 640,
  parameter int VER_ACTIVE_PIXELS     = 480,
  localparam int NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  localparam int X_WIDTH      = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH      = $clog2(VER_ACTIVE_PIXELS),
  localparam int LEN_WIDTH    = $clog2(OUTPUT_QUEUE_SIZE + 1),
  localparam int ADDR_WIDTH   = $clog2(OUTPUT_QUEUE_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    queue_length,
  output logic                    busy,
  output logic                    done,
  output logic                    queue_rd,
  output logic [ADDR_WIDTH-1:0]   queue_addr,
  input  logic [NUMBER_WIDTH:0]   queue_data,
  input  logic                    accel_can_read,
  input  logic                    accel_can_write,
  output logic                    accel_read_enable,
  output logic                    accel_write_enable,
  input  logic [15:0]             accel_read_data,
  output logic [15:0]             accel_write_data,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [X_WIDTH-1:0]      result_x,
  output logic [Y_WIDTH-1:0]      result_y,
  output logic                    result_skip
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | queue RAM read strobe for item i
  // LATCH  | capture queue_data into item register
  // TYPE   | write type word
  // INT    | write integer word
  // FRAC   | write fractional word, advance item
  // END    | write queue terminator
  // X      | write current x
  // READ   | read y for current x
  // RESULT | hold result until downstream accepts
  // TERM   | write sweep terminator
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_TYPE, S_INT, S_FRAC,
    S_END, S_X, S_READ, S_RESULT, S_TERM
  } state_t;

  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(HOR_ACTIVE_PIXELS - 1);

  state_t                            state;
  logic                              write_pending;
  logic                              read_pending;
  logic [LEN_WIDTH-1:0]              len;
  logic [LEN_WIDTH-1:0]              i;
  logic [X_WIDTH-1:0]                x;
  logic [INTEGER_PART_WIDTH-1:0]     item_int;
  logic [FRACTIONAL_PART_WIDTH-1:0]  item_frac;

  logic [LEN_WIDTH-1:0] len_clamped;
  logic [LEN_WIDTH-1:0] i_next;
  logic [X_WIDTH-1:0]   x_next;

  assign len_clamped = (queue_length > LEN_WIDTH'(OUTPUT_QUEUE_SIZE)) ?
                       LEN_WIDTH'(OUTPUT_QUEUE_SIZE) : queue_length;
  assign i_next      = i + LEN_WIDTH'(1);
  assign x_next      = x + X_WIDTH'(1);

  assign accel_write_enable = write_pending & accel_can_write;
  assign accel_read_enable  = read_pending & accel_can_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      write_pending    <= 1'b0;
      read_pending     <= 1'b0;
      len              <= '0;
      i                <= '0;
      x                <= '0;
      item_int         <= '0;
      item_frac        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      queue_rd         <= 1'b0;
      queue_addr       <= '0;
      accel_write_data <= '0;
      result_valid     <= 1'b0;
      result_x         <= '0;
      result_y         <= '0;
      result_skip      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len  <= len_clamped;
            busy <= 1'b1;
            i    <= '0;
            if (len_clamped == '0) begin
              accel_write_data <= 16'h0000;
              write_pending    <= 1'b1;
              state            <= S_END;
            end else begin
              queue_rd   <= 1'b1;
              queue_addr <= '0;
              state      <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          queue_rd <= 1'b0;
          state    <= S_LATCH;
        end
        S_LATCH: begin
          item_int         <= queue_data[NUMBER_WIDTH-1:FRACTIONAL_PART_WIDTH];
          item_frac        <= queue_data[FRACTIONAL_PART_WIDTH-1:0];
          accel_write_data <= {14'b0, 1'b1, queue_data[NUMBER_WIDTH]};
          write_pending    <= 1'b1;
          state            <= S_TYPE;
        end
        S_TYPE: begin
          if (accel_write_enable) begin
            accel_write_data <= {{(16-INTEGER_PART_WIDTH){1'b0}}, item_int};
            state            <= S_INT;
          end
        end
        S_INT: begin
          if (accel_write_enable) begin
            accel_write_data <= {{(16-FRACTIONAL_PART_WIDTH){1'b0}}, item_frac};
            state            <= S_FRAC;
          end
        end
        S_FRAC: begin
          if (accel_write_enable) begin
            i <= i_next;
            if (i_next == len) begin
              accel_write_data <= 16'h0000;
              state            <= S_END;
            end else begin
              write_pending <= 1'b0;
              queue_rd      <= 1'b1;
              queue_addr    <= i_next[ADDR_WIDTH-1:0];
              state         <= S_FETCH;
            end
          end
        end
        S_END: begin
          if (accel_write_enable) begin
            x                <= '0;
            accel_write_data <= 16'h0000;
            state            <= S_X;
          end
        end
        S_X: begin
          if (accel_write_enable) begin
            write_pending <= 1'b0;
            read_pending  <= 1'b1;
            state         <= S_READ;
          end
        end
        S_READ: begin
          if (accel_read_enable) begin
            read_pending <= 1'b0;
            result_x     <= x;
            result_y     <= accel_read_data[Y_WIDTH-1:0];
            result_skip  <= (accel_read_data == 16'hFFFF);
            result_valid <= 1'b1;
            state        <= S_RESULT;
          end
        end
        S_RESULT: begin
          // the next X word waits for acceptance so only one result is ever outstanding
          if (result_ready) begin
            result_valid  <= 1'b0;
            write_pending <= 1'b1;
            if (x == X_LAST) begin
              accel_write_data <= 16'hFFFF;
              state            <= S_TERM;
            end else begin
              x                <= x_next;
              accel_write_data <= {{(16-X_WIDTH){1'b0}}, x_next};
              state            <= S_X;
            end
          end
        end
        S_TERM: begin
          if (accel_write_enable) begin
            write_pending <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_accel_driver.sv
// Scoreboard bench for plot_accel_driver: stimulus pushes expected words/results, a monitor pops and compares.
module tb_plot_accel_driver;
  localparam int HOR = 4;
  localparam int OQS = 64;
  localparam int XW  = 2;
  localparam int YW  = 9;
  localparam int LW  = 7;
  localparam int AW  = 6;
  localparam int T_ITEM = 0, T_TYPE = 1, T_END = 2, T_X = 3, T_TERM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] queue_length;
  logic          busy, done, queue_rd;
  logic [AW-1:0] queue_addr;
  logic [16:0]   queue_data;
  logic          accel_can_read, accel_can_write;
  logic          accel_read_enable, accel_write_enable;
  logic [15:0]   accel_read_data, accel_write_data;
  logic          result_valid, result_ready;
  logic [XW-1:0] result_x;
  logic [YW-1:0] result_y;
  logic          result_skip;

  always #5 clk = ~clk;

  plot_accel_driver #(
    .INTEGER_PART_WIDTH(8), .FRACTIONAL_PART_WIDTH(8), .OUTPUT_QUEUE_SIZE(OQS),
    .HOR_ACTIVE_PIXELS(HOR), .VER_ACTIVE_PIXELS(480)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .queue_length(queue_length),
    .busy(busy), .done(done), .queue_rd(queue_rd), .queue_addr(queue_addr),
    .queue_data(queue_data), .accel_can_read(accel_can_read),
    .accel_can_write(accel_can_write), .accel_read_enable(accel_read_enable),
    .accel_write_enable(accel_write_enable), .accel_read_data(accel_read_data),
    .accel_write_data(accel_write_data), .result_valid(result_valid),
    .result_ready(result_ready), .result_x(result_x), .result_y(result_y),
    .result_skip(result_skip)
  );

  // queue RAM and accelerator models
  logic [16:0]   ram [OQS];
  logic [15:0]   y_tab [HOR];
  logic [XW-1:0] cur_x = '0;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (queue_rd) queue_data <= ram[queue_addr];
  end
  assign accel_read_data = y_tab[cur_x];

  typedef struct { logic [15:0] d; int tag; } wexp_t;
  typedef struct { logic [XW-1:0] x; logic [YW-1:0] y; logic skip; } rexp_t;
  wexp_t exp_w[$];
  rexp_t exp_r[$];

  int n_checks = 0, n_pass = 0;
  int done_cnt = 0, done_cyc = 0, rd_cnt = 0, x_writes = 0;
  int start_cyc = 0, done_base = 0;
  int p_hs = 100, cw_hold = 0, rdy_hold = 0;
  bit forced_cw = 0, stall_int_req = 0, rdy_stall_req = 0;
  bit prev_stall = 0, expect_read = 0;
  logic [XW-1:0] prev_x = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // handshake driver
  initial begin
    accel_can_write = 1'b0; accel_can_read = 1'b0; result_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy_stall_req && result_valid && result_x == XW'(1)) begin
        rdy_hold = 5; rdy_stall_req = 0;
      end
      forced_cw = (cw_hold > 0);
      accel_can_write = forced_cw ? 1'b0 : ($urandom_range(99) < p_hs);
      if (cw_hold > 0) cw_hold--;
      accel_can_read = ($urandom_range(99) < p_hs);
      result_ready = (rdy_hold > 0) ? 1'b0 : ($urandom_range(99) < p_hs);
      if (rdy_hold > 0) rdy_hold--;
    end
  end

  // monitor: samples the cycle's settled handshakes ahead of the next posedge
  initial begin
    wexp_t w;
    rexp_t r;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (forced_cw) begin
          check("stall_enable_low", accel_write_enable, 0);
          if (exp_w.size() > 0) check("stall_data_stable", accel_write_data, exp_w[0].d);
        end
        if (accel_write_enable) begin
          if (exp_w.size() == 0) fail_now("unexpected_write");
          else begin
            w = exp_w.pop_front();
            check("write_word", accel_write_data, w.d);
            if (w.tag == T_X) begin
              cur_x = accel_write_data[XW-1:0];
              x_writes++;
              expect_read = 1;
              check("x_write_no_outstanding", result_valid, 0);
            end
            if (w.tag == T_TYPE && stall_int_req) begin
              cw_hold = 3; stall_int_req = 0;
            end
          end
        end
        if (accel_read_enable) begin
          check("read_after_x", expect_read, 1);
          expect_read = 0;
        end
        if (result_valid) begin
          if (prev_stall) check("result_hold_x", result_x, prev_x);
          if (result_ready) begin
            if (exp_r.size() == 0) fail_now("unexpected_result");
            else begin
              r = exp_r.pop_front();
              check("result_x", result_x, r.x);
              check("result_y", result_y, r.y);
              check("result_skip", result_skip, r.skip);
            end
          end
          prev_stall = !result_ready;
          prev_x = result_x;
        end else begin
          if (prev_stall) check("result_valid_held", result_valid, 1);
          prev_stall = 0;
        end
        if (queue_rd) begin
          check("queue_addr", queue_addr, rd_cnt);
          rd_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic launch(input int ql);
    int l;
    wexp_t w;
    rexp_t r;
    l = (ql > OQS) ? OQS : ql;
    for (int k = 0; k < l; k++) begin
      w.d = 16'(2 + ram[k][16]);   w.tag = T_TYPE; exp_w.push_back(w);
      w.d = 16'(ram[k][15:8]);     w.tag = T_ITEM; exp_w.push_back(w);
      w.d = 16'(ram[k][7:0]);      w.tag = T_ITEM; exp_w.push_back(w);
    end
    w.d = 16'h0000; w.tag = T_END; exp_w.push_back(w);
    for (int xi = 0; xi < HOR; xi++) begin
      w.d = 16'(xi); w.tag = T_X; exp_w.push_back(w);
      r.x = XW'(xi);
      r.y = y_tab[xi][YW-1:0];
      r.skip = (y_tab[xi] == 16'hFFFF);
      exp_r.push_back(r);
    end
    w.d = 16'hFFFF; w.tag = T_TERM; exp_w.push_back(w);
    @(negedge clk);
    rd_cnt = 0;
    done_base = done_cnt;
    queue_length = LW'(ql);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    #2;
    check("busy_after_start", busy, 1);
  endtask

  task automatic finish_pass(input int exp_rd, input int exp_lat);
    int n;
    n = 0;
    while (done_cnt == done_base && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == done_base) fail_now("done_timeout");
    repeat (2) @(negedge clk);
    #2;
    check("busy_after_done", busy, 0);
    check("done_pulse_count", done_cnt - done_base, 1);
    check("writes_drained", exp_w.size(), 0);
    check("results_drained", exp_r.size(), 0);
    check("queue_reads", rd_cnt, exp_rd);
    if (exp_lat >= 0) check("pass_latency", done_cyc - start_cyc, exp_lat);
  endtask

  task automatic rand_items(input int n);
    for (int k = 0; k < n; k++) ram[k] = 17'($urandom);
  endtask

  task automatic rand_y();
    for (int xi = 0; xi < HOR; xi++)
      y_tab[xi] = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; queue_length = '0;
    for (int k = 0; k < OQS; k++) ram[k] = '0;
    for (int xi = 0; xi < HOR; xi++) y_tab[xi] = '0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_outputs", {busy, done, queue_rd, queue_addr, accel_write_enable,
          accel_read_enable, accel_write_data, result_valid, result_x, result_y, result_skip}, 0);
    @(negedge clk);
    rst = 1'b0;

    // directed pass: two items, y = x + 10, no stalls
    ram[0] = {1'b1, 8'h03, 8'h80};
    ram[1] = {1'b0, 8'h00, 8'h01};
    for (int xi = 0; xi < HOR; xi++) y_tab[xi] = 16'(xi + 10);
    p_hs = 100;
    launch(2);
    finish_pass(2, 5*2 + 3*HOR + 3);

    // empty queue goes straight to the terminator
    rand_y();
    launch(0);
    finish_pass(0, 3*HOR + 3);

    // skip pixel, result backpressure, write stall in INT, ignored start mid-pass
    rand_items(3);
    for (int xi = 0; xi < HOR; xi++) y_tab[xi] = 16'(xi + 10);
    y_tab[2] = 16'hFFFF;
    stall_int_req = 1; rdy_stall_req = 1;
    launch(3);
    repeat (4) @(negedge clk);
    queue_length = LW'(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_pass(3, -1);
    check("int_stall_taken", stall_int_req, 0);
    check("ready_stall_taken", rdy_stall_req, 0);

    // oversize length clamps, random handshakes
    rand_items(OQS);
    rand_y();
    p_hs = 60;
    launch(70);
    finish_pass(OQS, -1);

    // reset during the sweep, then a fresh full pass
    rand_items(4);
    rand_y();
    p_hs = 80;
    n = x_writes;
    launch(4);
    while (x_writes < n + 2 && cyc < start_cyc + 3000) @(negedge clk);
    if (x_writes < n + 2) fail_now("x_sweep_timeout");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("reset_mid_outputs", {busy, done, queue_rd, queue_addr, accel_write_enable,
          accel_read_enable, accel_write_data, result_valid, result_x, result_y, result_skip}, 0);
    exp_w.delete();
    exp_r.delete();
    prev_stall = 0; expect_read = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", done_cnt - done_base, 0);
    rand_items(5);
    rand_y();
    launch(5);
    finish_pass(5, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/plot_accel_driver.md
Name: plot_accel_driver

Overview:
Host-side initiator for the stack-machine accelerator word protocol. On `start` it performs three steps:
- streams an RPN output queue from a synchronous queue RAM into the accelerator;
- sweeps x = 0 .. HOR_ACTIVE_PIXELS-1, writing each x and reading back y;
- terminates the sweep.

Each (x, y/skip) pair is emitted on a valid/ready result stream toward the framebuffer writer.

Parameters:
INTEGER_PART_WIDTH, 8, integer bits of a queue item value
FRACTIONAL_PART_WIDTH, 8, fractional bits of a queue item value
OUTPUT_QUEUE_SIZE, 64, max queue items; RAM depth
HOR_ACTIVE_PIXELS, 640, sweep length; X_WIDTH = clog2(HOR_ACTIVE_PIXELS)
VER_ACTIVE_PIXELS, 480, Y_WIDTH = clog2(VER_ACTIVE_PIXELS)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse, begins a plot pass; ignored while busy
queue_length  in  clog2(OUTPUT_QUEUE_SIZE+1)  items to send, sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after terminator word written
queue_rd  out  1  queue RAM read strobe
queue_addr  out  clog2(OUTPUT_QUEUE_SIZE)  queue RAM address
queue_data  in  NUMBER_WIDTH+1  {type, integer, fractional}; valid the cycle after queue_rd
accel_can_read  in  1  accelerator has y available
accel_can_write  in  1  accelerator accepts a word
accel_read_enable  out  1  consume y word
accel_write_enable  out  1  write accel_write_data
accel_read_data  in  16  y, or 16'hFFFF = skip pixel
accel_write_data  out  16  protocol word
result_valid  out  1  result pair available
result_ready  in  1  downstream accepts result
result_x  out  X_WIDTH  pixel column
result_y  out  Y_WIDTH  accel_read_data[Y_WIDTH-1:0]
result_skip  out  1  accel_read_data == 16'hFFFF

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0: busy, done, queue_rd, queue_addr, accel_*_enable, accel_write_data, result_*. Item and x counters cleared.
- Write handshake: accel_write_enable = write_pending & accel_can_write (combinational qualify). A word is transferred in a cycle with enable=1. accel_write_data is held stable while write_pending.
- Read handshake: accel_read_enable = read_pending & accel_can_read. accel_read_data is sampled in that same cycle.
- Protocol words:
  - TYPE = {14'b0, 1'b1, item_type}.
  - INT = zero-extended queue_data integer field.
  - FRAC = zero-extended fractional field.
  - END = 16'h0000 (bit1=0 ends the queue).
  - X = zero-extended x.
  - TERM = 16'hFFFF.
- States:
  - IDLE: on start, latch L = min(queue_length, OUTPUT_QUEUE_SIZE); busy<=1; i<=0. If L==0 go END, else FETCH.
  - FETCH: queue_rd=1 with queue_addr=i for one cycle -> LATCH.
  - LATCH: capture queue_data into item register -> TYPE.
  - TYPE: write TYPE word -> INT.
  - INT: write INT word -> FRAC.
  - FRAC: write FRAC word; i<=i+1. If i+1==L go END, else FETCH.
  - END: write END -> X with x=0.
  - X: write X word -> READ.
  - READ: read y; load result regs; result_valid<=1 -> RESULT.
  - RESULT: hold result until result_valid & result_ready, then result_valid<=0. If x==HOR_ACTIVE_PIXELS-1 go TERM, else x<=x+1 and go X.
  - TERM: write TERM; busy<=0, done<=1 -> IDLE.
- Latency floor:
  - per item: 5 cycles (FETCH + LATCH + 3 writes);
  - per pixel: 3 cycles with can_write/can_read/result_ready always high.
- Stalls: any state waits indefinitely on its handshake with no side effects. The next X word is never written before the prior result is accepted, so at most one result is outstanding.
- start while busy: ignored, no effect on latched L.
- queue_length > OUTPUT_QUEUE_SIZE: clamped to OUTPUT_QUEUE_SIZE.
- Skip: result_y still carries low bits of 16'hFFFF; consumers must honour result_skip.
- Reset mid-pass: immediate return to IDLE, no done. The accelerator has no reset of its own, so rst must be applied to both blocks together (shared system reset).

Test Plan:
- L=2, items {1,8'h03,8'h80},{0,8'h00,8'h01}; HOR=4; accelerator model returns y=x+10.
  -> Write sequence 0003,0003,0080,0002,0000,0001,0000, then 0000,0001,0002,0003, then FFFF.
  -> Results (0,10),(1,11),(2,12),(3,13); one done pulse.
- queue_length=0 -> first write is 0000, then X sweep; no queue_rd asserted.
- Model returns FFFF for x=2 -> result_x=2, result_skip=1; other pixels skip=0.
- result_ready held low 5 cycles at x=1 -> result_valid stays high with x=1 stable; no X=2 write until accepted.
- accel_can_write low 3 cycles during INT -> enable low, data stable, sequence unchanged; start pulsed mid-pass ignored.
- queue_length=70 with size 64 -> exactly 64 items (192 item words) sent.
- rst asserted during the X sweep -> all outputs 0 next edge; a new start runs a full correct pass.
